// File: rtl/kong_game_ctrl.sv
// Game-flow sequencer for kong: title/respawn/play/dying/level-done/game-over,
// with lives, level and bonus bookkeeping. Everything steps on the frame pulse.
module kong_game_ctrl #(
    parameter int unsigned INIT_LIVES     = 3,
    parameter int unsigned NUM_LEVELS     = 4,
    parameter int unsigned RESPAWN_FRAMES = 30,
    parameter int unsigned DEATH_FRAMES   = 90,
    parameter int unsigned DONE_FRAMES    = 120,
    parameter int unsigned BONUS_START    = 5000,
    parameter int unsigned BONUS_STEP     = 100,
    parameter int unsigned BONUS_PERIOD   = 60,
    parameter int          FALL_LIMIT_Y   = 470
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               key_start,
    input  logic               collision_enemy,
    input  logic               collision_goal,
    input  logic signed [10:0] kong_topLeftY,
    output logic [2:0]         game_state,
    output logic               kong_respawnN,
    output logic               input_enable,
    output logic [2:0]         lives,
    output logic [2:0]         level,
    output logic [13:0]        bonus,
    output logic [13:0]        score_add,
    output logic               score_add_valid
);

    typedef enum logic [2:0] {
        StTitle     = 3'd0,
        StRespawn   = 3'd1,
        StPlay      = 3'd2,
        StDying     = 3'd3,
        StLevelDone = 3'd4,
        StGameOver  = 3'd5
    } state_e;

    localparam logic signed [10:0] FallY       = 11'(FALL_LIMIT_Y);
    localparam logic [7:0]         RespawnLast = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0]         DeathLast   = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0]         DoneLast    = 8'(DONE_FRAMES - 1);
    localparam logic [7:0]         PeriodLast  = 8'(BONUS_PERIOD - 1);
    localparam logic [2:0]         LevelLast   = 3'(NUM_LEVELS - 1);
    localparam logic [13:0]        BonusInit   = 14'(BONUS_START);

    state_e      state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  bonus_cnt_q, bonus_cnt_d;
    logic [2:0]  lives_q, lives_d;
    logic [2:0]  level_q, level_d;
    logic [13:0] bonus_q, bonus_d;
    logic [13:0] score_add_q, score_add_d;
    logic        score_valid_q, score_valid_d;

    logic start_seen_q, enemy_seen_q, goal_seen_q, fell_seen_q;
    logic start_ev, enemy_ev, goal_ev, fell_ev;

    // Events on the frame cycle itself still count toward the frame being closed.
    assign start_ev = start_seen_q | key_start;
    assign enemy_ev = enemy_seen_q | collision_enemy;
    assign goal_ev  = goal_seen_q | collision_goal;
    assign fell_ev  = fell_seen_q | (kong_topLeftY > FallY);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_seen_q <= 1'b0;
            enemy_seen_q <= 1'b0;
            goal_seen_q  <= 1'b0;
            fell_seen_q  <= 1'b0;
        end else if (startOfFrame) begin
            start_seen_q <= 1'b0;
            enemy_seen_q <= 1'b0;
            goal_seen_q  <= 1'b0;
            fell_seen_q  <= 1'b0;
        end else begin
            start_seen_q <= start_ev;
            enemy_seen_q <= enemy_ev;
            goal_seen_q  <= goal_ev;
            fell_seen_q  <= fell_ev;
        end
    end

    // Borrow out of the 15-bit difference means the step overshot zero.
    logic [14:0] bonus_diff;
    logic [13:0] bonus_dec;
    assign bonus_diff = {1'b0, bonus_q} - 15'(BONUS_STEP);
    assign bonus_dec  = bonus_diff[14] ? 14'd0 : bonus_diff[13:0];

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        bonus_cnt_d   = bonus_cnt_q;
        lives_d       = lives_q;
        level_d       = level_q;
        bonus_d       = bonus_q;
        score_add_d   = score_add_q;
        score_valid_d = 1'b0;

        if (startOfFrame) begin
            case (state_q)
                StTitle: begin
                    if (start_ev) begin
                        state_d = StRespawn;
                        lives_d = 3'(INIT_LIVES);
                        level_d = 3'd0;
                        bonus_d = BonusInit;
                    end
                end
                StRespawn: begin
                    if (frame_cnt_q == RespawnLast) begin
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (bonus_cnt_q == PeriodLast) begin
                        bonus_cnt_d = 8'd0;
                        bonus_d     = bonus_dec;
                    end else begin
                        bonus_cnt_d = bonus_cnt_q + 8'd1;
                    end
                    // Death outranks a goal reached in the same frame.
                    if (enemy_ev || fell_ev || (bonus_q == 14'd0)) begin
                        state_d = StDying;
                        lives_d = lives_q - 3'd1;
                    end else if (goal_ev) begin
                        state_d       = StLevelDone;
                        score_add_d   = bonus_q;
                        score_valid_d = 1'b1;
                        if (level_q == LevelLast) begin
                            level_d = 3'd0;
                            lives_d = (lives_q == 3'd7) ? 3'd7 : lives_q + 3'd1;
                        end else begin
                            level_d = level_q + 3'd1;
                        end
                    end
                end
                StDying: begin
                    if (frame_cnt_q == DeathLast) begin
                        if (lives_q == 3'd0) begin
                            state_d = StGameOver;
                        end else begin
                            state_d = StRespawn;
                            bonus_d = BonusInit;
                        end
                    end
                end
                StLevelDone: begin
                    if (frame_cnt_q == DoneLast) begin
                        state_d = StRespawn;
                        bonus_d = BonusInit;
                    end
                end
                StGameOver: begin
                    if (start_ev) begin
                        state_d = StTitle;
                    end
                end
                default: state_d = StTitle;
            endcase

            if (state_d != state_q) begin
                frame_cnt_d = 8'd0;
                bonus_cnt_d = 8'd0;
            end else if (state_q inside {StRespawn, StDying, StLevelDone}) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= StTitle;
            frame_cnt_q   <= 8'd0;
            bonus_cnt_q   <= 8'd0;
            lives_q       <= 3'd0;
            level_q       <= 3'd0;
            bonus_q       <= 14'd0;
            score_add_q   <= 14'd0;
            score_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            bonus_cnt_q   <= bonus_cnt_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            bonus_q       <= bonus_d;
            score_add_q   <= score_add_d;
            score_valid_q <= score_valid_d;
        end
    end

    assign game_state      = state_q;
    assign kong_respawnN   = (state_q == StPlay) || (state_q == StDying) ||
                             (state_q == StLevelDone);
    assign input_enable    = (state_q == StPlay);
    assign lives           = lives_q;
    assign level           = level_q;
    assign bonus           = bonus_q;
    assign score_add       = score_add_q;
    assign score_add_valid = score_valid_q;

endmodule

// File: doc/kong_game_ctrl.md
Name: kong_game_ctrl

Overview:
- Game-flow sequencer for the kong character datapath.
- Decides when kong is held in respawn, when keypad input reaches it, and when a life or level ends.
- Tracks lives, level and the per-level bonus timer.
- Sits beside the kong motion block: its respawn/input-enable outputs gate that block's reset and ask_move_* inputs; its counters feed the HUD/score drawers.

Parameters:
INIT_LIVES, 3, lives loaded on game start (1..7)
NUM_LEVELS, 4, number of levels; level index wraps to 0 after the last (1..8)
RESPAWN_FRAMES, 30, frames kong is held at spawn with input disabled (1..255)
DEATH_FRAMES, 90, frames of death animation before respawn/game over (1..255)
DONE_FRAMES, 120, frames of level-complete pause (1..255)
BONUS_START, 5000, bonus value loaded at each respawn (≤16383)
BONUS_STEP, 100, amount subtracted per bonus period
BONUS_PERIOD, 60, frames per bonus decrement (1..255)
FALL_LIMIT_Y, 470, kong topLeftY above which kong has fallen off screen

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clock pulse per video frame
key_start  in  1  start key level, may be asserted any cycle
collision_enemy  in  1  per-pixel kong/enemy overlap
collision_goal  in  1  per-pixel kong/goal overlap
kong_topLeftY  in  11 signed  kong top-left Y in pixels
game_state  out  3  TITLE=0, RESPAWN=1, PLAY=2, DYING=3, LEVEL_DONE=4, GAME_OVER=5
kong_respawnN  out  1  active-low hold of kong motion block; low in TITLE, RESPAWN, GAME_OVER
input_enable  out  1  high only in PLAY; gates ask_move_* to kong
lives  out  3  remaining lives
level  out  3  current level index
bonus  out  14  current bonus value
score_add  out  14  bonus awarded on level completion
score_add_valid  out  1  one-clock pulse qualifying score_add

Behaviour:
- Reset (async, any state, mid-frame included): state=TITLE, lives=0, level=0, bonus=0, score_add=0, score_add_valid=0, frame counter=0, all event latches cleared. kong_respawnN=0, input_enable=0.
- Event latches: start_seen, enemy_seen, goal_seen accumulate (OR) their inputs every cycle between frames.
  - fell_seen sets when kong_topLeftY > FALL_LIMIT_Y (signed compare).
  - All latches clear on the startOfFrame cycle, in the same edge that consumes them.
- State, counters and outputs update only on the startOfFrame edge. score_add_valid is the only exception: it is a pulse, high for exactly the clock after that edge.
- frame_cnt (8 bit) is cleared on every state entry and increments on each startOfFrame while in RESPAWN, DYING or LEVEL_DONE.
- bonus_cnt (8 bit) runs only in PLAY. When it reaches BONUS_PERIOD-1 it wraps to 0 and bonus decrements by BONUS_STEP, saturating at 0.
- Transitions at startOfFrame:
  - TITLE: if start_seen -> RESPAWN. Load lives=INIT_LIVES, level=0, bonus=BONUS_START.
  - RESPAWN: if frame_cnt==RESPAWN_FRAMES-1 -> PLAY.
  - PLAY: checks in priority order:
    1. enemy_seen or fell_seen or bonus==0 -> DYING, lives-1. A simultaneous goal is ignored.
    2. goal_seen -> LEVEL_DONE. score_add=bonus, score_add_valid pulses. level=(level==NUM_LEVELS-1)?0:level+1. Wrapping also grants lives+1, saturating at 7.
  - DYING: when frame_cnt==DEATH_FRAMES-1: if lives==0 -> GAME_OVER, else -> RESPAWN with bonus=BONUS_START.
  - LEVEL_DONE: when frame_cnt==DONE_FRAMES-1 -> RESPAWN with bonus=BONUS_START.
  - GAME_OVER: if start_seen -> TITLE. Lives, level and bonus are left unchanged until the next game start.
- Events outside PLAY (enemy, goal, fall) are latched and then discarded with no effect.
- A bonus decrement to 0 and an enemy hit in the same frame cause a single death; lives decrement by exactly 1.
- lives never underflows: DYING is entered only from PLAY, where lives≥1.
- Arithmetic: bonus subtraction is done at 15 bits and clamped to 0. All counters are unsigned.

Test Plan:
- Reset, then key_start pulse one cycle mid-frame -> next startOfFrame: state=RESPAWN, lives=3, level=0, bonus=5000, kong_respawnN=0. After 30 more frames: state=PLAY, input_enable=1, kong_respawnN=1.
- PLAY with no events for 120 frames -> bonus=4800. Continue until bonus=0 -> next frame state=DYING, lives=2.
- collision_enemy and collision_goal both pulsed in one PLAY frame -> DYING, lives decremented by 1, no score_add_valid.
- Goal hit at level 3 with bonus=4300 -> score_add=4300 with a 1-clock score_add_valid. level=0, lives+1. After 120 frames: RESPAWN with bonus=5000.
- kong_topLeftY=471 for one cycle in PLAY with lives=1 -> DYING with lives=0. After 90 frames: GAME_OVER. key_start -> TITLE.
- resetN asserted mid-DYING, asynchronously off-edge -> outputs immediately at reset values, state=TITLE. An enemy pulse during TITLE has no effect.
